// File: rtl/leaf_credit_tx_if.sv
// Bundle for the leaf transmit path: user streams in, BFT packets out, and BFT control packets back in.
// The master side drives users and BFT control. The slave side is the transmitter.
interface leaf_credit_tx_if #(
  parameter int PACKET_BITS  = 49,
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_IN_PORTS = 4
) ();
  logic [PACKET_BITS-1:0]               din_leaf_bft2interface;
  logic [PACKET_BITS-1:0]               dout_leaf_interface2bft;
  logic                                 resend;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_IN_PORTS-1:0]              vld_user2interface;
  logic [NUM_IN_PORTS-1:0]              ack_interface2user;

  modport master (
    output din_leaf_bft2interface, resend, din_leaf_user2interface, vld_user2interface,
    input  dout_leaf_interface2bft, ack_interface2user
  );

  modport slave (
    input  din_leaf_bft2interface, resend, din_leaf_user2interface, vld_user2interface,
    output dout_leaf_interface2bft, ack_interface2user
  );
endinterface

// File: rtl/leaf_credit_tx.sv
// Leaf transmit side: round-robin arbitration over user ap_vld/ap_ack streams into BFT packets.
// Each channel has runtime-programmed destinations and credit flow control, and the last packet can be resent.
module leaf_credit_tx #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_IN_PORTS          = 4,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input logic           clk,
  input logic           reset,
  leaf_credit_tx_if.slave bus
);
  localparam int CW       = NUM_BRAM_ADDR_BITS + 1;
  localparam int CRED_MAX = 1 << NUM_BRAM_ADDR_BITS;
  localparam int N        = NUM_IN_PORTS;
  localparam int PW       = NUM_PORT_BITS;

  logic [CW-1:0]            credit_q [N];
  logic [CW-1:0]            credit_d [N];
  logic [NUM_ADDR_BITS-1:0] seq_q    [N];
  logic [NUM_ADDR_BITS-1:0] seq_d    [N];
  logic [NUM_LEAF_BITS-1:0] leaf_q   [N];
  logic [NUM_LEAF_BITS-1:0] leaf_d   [N];
  logic [PW-1:0]            port_q   [N];
  logic [PW-1:0]            port_d   [N];
  logic [N-1:0]             dv_q, dv_d;
  logic [PW-1:0]            rr_q, rr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [PACKET_BITS-1:0]   last_q, last_d;
  logic [N-1:0]             ack_q, ack_d;

  logic [PACKET_BITS-1:0] ctrl;
  logic [PW-1:0]          ctrl_ch;
  logic [1:0]             ctrl_op;
  logic                   ctrl_hit, cfg_hit, ret_hit;
  logic                   unused_ctrl;

  assign ctrl        = bus.din_leaf_bft2interface;
  assign ctrl_ch     = ctrl[PW-1:0];
  assign ctrl_op     = ctrl[PAYLOAD_BITS-1 -: 2];
  assign ctrl_hit    = ctrl[PACKET_BITS-1] & ctrl[PACKET_BITS-2] & (int'(ctrl_ch) < N);
  assign cfg_hit     = ctrl_hit & (ctrl_op == 2'b00);
  assign ret_hit     = ctrl_hit & (ctrl_op == 2'b01);
  assign unused_ctrl = ^ctrl;

  // Saturating credit update; a return and a grant in the same cycle combine before saturation.
  function automatic logic [CW-1:0] cred_next(input logic [CW-1:0] c, input logic add, input logic sub);
    logic [31:0] s;
    s = 32'(c) + (add ? 32'(FREESPACE_UPDATE_SIZE) : 32'd0) - (sub ? 32'd1 : 32'd0);
    return (s > 32'(CRED_MAX)) ? CW'(CRED_MAX) : CW'(s);
  endfunction

  logic [N-1:0]           elig;
  logic                   gnt;
  logic [PW-1:0]          gnt_idx;
  logic [PACKET_BITS-1:0] gnt_pkt;
  int                     sel;

  // A channel acked last cycle is still showing the same data, so it sits out one cycle.
  always_comb begin
    for (int i = 0; i < N; i++)
      elig[i] = bus.vld_user2interface[i] & dv_q[i] & (credit_q[i] != '0) & ~ack_q[i];
  end

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    gnt_pkt = '0;
    sel     = 0;
    if (!bus.resend) begin
      for (int k = 0; k < N; k++) begin
        sel = (int'(rr_q) + k) % N;
        if (!gnt && elig[sel]) begin
          gnt     = 1'b1;
          gnt_idx = PW'(sel);
          gnt_pkt = {1'b1, 1'b0, leaf_q[sel], port_q[sel], seq_q[sel],
                     bus.din_leaf_user2interface[sel*PAYLOAD_BITS +: PAYLOAD_BITS]};
        end
      end
    end
  end

  always_comb begin
    credit_d = credit_q;
    seq_d    = seq_q;
    leaf_d   = leaf_q;
    port_d   = port_q;
    dv_d     = dv_q;
    rr_d     = rr_q;
    last_d   = last_q;
    ack_d    = '0;
    if (bus.resend) begin
      dout_d = last_q;
    end else if (gnt) begin
      dout_d = gnt_pkt;
      last_d = gnt_pkt;
      rr_d   = (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
    end else begin
      dout_d = {1'b0, dout_q[PACKET_BITS-2:0]};
    end
    for (int i = 0; i < N; i++) begin
      if (gnt && int'(gnt_idx) == i) begin
        ack_d[i] = 1'b1;
        seq_d[i] = seq_q[i] + 1'b1;
      end
      credit_d[i] = cred_next(credit_q[i], ret_hit && int'(ctrl_ch) == i, gnt && int'(gnt_idx) == i);
      if (cfg_hit && int'(ctrl_ch) == i) begin
        leaf_d[i] = ctrl[8 +: NUM_LEAF_BITS];
        port_d[i] = ctrl[16 +: PW];
        dv_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        credit_q[i] <= CW'(CRED_MAX);
        seq_q[i]    <= '0;
        leaf_q[i]   <= '0;
        port_q[i]   <= '0;
      end
      dv_q   <= '0;
      rr_q   <= '0;
      dout_q <= '0;
      last_q <= '0;
      ack_q  <= '0;
    end else begin
      credit_q <= credit_d;
      seq_q    <= seq_d;
      leaf_q   <= leaf_d;
      port_q   <= port_d;
      dv_q     <= dv_d;
      rr_q     <= rr_d;
      dout_q   <= dout_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.dout_leaf_interface2bft = dout_q;
  assign bus.ack_interface2user      = ack_q;
endmodule

// File: tb/tb_leaf_credit_tx.sv
// Bench for leaf_credit_tx: directed scenarios plus a random phase, checked against a per-channel behavioural model.
module tb_leaf_credit_tx;
  localparam int PB = 49, PL = 32, LB = 4, PT = 4, AB = 7, N = 4, BB = 7, FS = 64, CMAX = 128;

  logic clk = 1'b0;
  logic reset;

  leaf_credit_tx_if #(.PACKET_BITS(PB), .PAYLOAD_BITS(PL), .NUM_IN_PORTS(N)) bus ();

  leaf_credit_tx #(
    .PACKET_BITS(PB), .PAYLOAD_BITS(PL), .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PT),
    .NUM_ADDR_BITS(AB), .NUM_IN_PORTS(N), .NUM_BRAM_ADDR_BITS(BB), .FREESPACE_UPDATE_SIZE(FS)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int             m_credit [N];
  int             m_seq    [N];
  int             m_leaf   [N];
  int             m_port   [N];
  bit             m_dv     [N];
  int             m_rr;
  logic [N-1:0]   m_ack;
  logic [PB-1:0]  m_last;
  logic [PB-1:0]  m_dout;

  logic [PL-1:0]  udata [N];
  logic [N-1:0]   uvld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_credit[i] = CMAX; m_seq[i] = 0; m_leaf[i] = 0; m_port[i] = 0; m_dv[i] = 0;
    end
    m_rr = 0; m_ack = '0; m_last = '0; m_dout = '0;
  endtask

  function automatic logic [PB-1:0] mk_ctrl(input logic [1:0] op, input int ch, input int leaf, input int port);
    logic [PB-1:0] p;
    p = '0;
    p[PB-1] = 1'b1;
    p[PB-2] = 1'b1;
    p[PL-1 -: 2] = op;
    p[3:0]   = 4'(ch);
    p[8 +: 4]  = 4'(leaf);
    p[16 +: 4] = 4'(port);
    return p;
  endfunction

  // One clock: apply inputs, predict with the model, then check outputs 1 time unit after the edge.
  task automatic step(input logic [PB-1:0] ctrl, input logic rs);
    logic [PB-1:0] exp;
    logic [N-1:0]  eack;
    int            g;
    bus.din_leaf_bft2interface = ctrl;
    bus.resend = rs;
    bus.vld_user2interface = uvld;
    for (int i = 0; i < N; i++) bus.din_leaf_user2interface[i*PL +: PL] = udata[i];
    eack = '0;
    g = -1;
    if (rs) begin
      exp = m_last;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (g < 0 && uvld[c] && m_dv[c] && m_credit[c] > 0 && !m_ack[c]) g = c;
      end
      if (g >= 0) begin
        exp = {1'b1, 1'b0, 4'(m_leaf[g]), 4'(m_port[g]), 7'(m_seq[g]), udata[g]};
        m_last = exp;
        m_seq[g] = (m_seq[g] + 1) % (1 << AB);
        m_credit[g] = m_credit[g] - 1;
        m_rr = (g + 1) % N;
        eack[g] = 1'b1;
      end else begin
        exp = {1'b0, m_dout[PB-2:0]};
      end
    end
    if (ctrl[PB-1] && ctrl[PB-2]) begin
      int ch;
      ch = int'(ctrl[3:0]);
      if (ch < N) begin
        if (ctrl[PL-1 -: 2] == 2'b00) begin
          m_leaf[ch] = int'(ctrl[8 +: 4]); m_port[ch] = int'(ctrl[16 +: 4]); m_dv[ch] = 1;
        end else if (ctrl[PL-1 -: 2] == 2'b01) begin
          m_credit[ch] = (m_credit[ch] + FS > CMAX) ? CMAX : m_credit[ch] + FS;
        end
      end
    end
    m_dout = exp;
    m_ack  = eack;
    @(posedge clk); #1;
    chk("dout_valid", 64'(bus.dout_leaf_interface2bft[PB-1]), 64'(exp[PB-1]));
    if (exp[PB-1]) chk("dout_pkt", 64'(bus.dout_leaf_interface2bft), 64'(exp));
    chk("ack", 64'(bus.ack_interface2user), 64'(eack));
    for (int i = 0; i < N; i++) if (eack[i]) udata[i] = $urandom;
    bus.din_leaf_bft2interface = '0;
    bus.resend = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    uvld = '0;
    bus.vld_user2interface = '0;
    bus.din_leaf_bft2interface = '0;
    bus.resend = 1'b0;
    model_reset();
    @(posedge clk); #3;
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [PB-1:0] p;
    int            n, expch, last_seq;
    int            cnt [N];
    bit            wrapped;

    reset = 1'b0;
    uvld = '0;
    bus.din_leaf_bft2interface = '0;
    bus.resend = 1'b0;
    bus.vld_user2interface = '0;
    bus.din_leaf_user2interface = '0;
    for (int i = 0; i < N; i++) udata[i] = $urandom;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
    chk("reset_ack", 64'(bus.ack_interface2user), 64'd0);
    for (int i = 0; i < N; i++) chk("reset_credit", 64'(dut.credit_q[i]), 64'(CMAX));
    #2 reset = 1'b1;

    // Resend before any packet yields valid=0
    step('0, 1'b1);

    // Single packet on ch0 to leaf 3 port 2
    step(mk_ctrl(2'b00, 0, 3, 2), 1'b0);
    uvld = 4'b0001;
    udata[0] = 32'hDEADBEEF;
    step('0, 1'b0);
    p = {1'b1, 1'b0, 4'h3, 4'h2, 7'd0, 32'hDEADBEEF};
    chk("t1_pkt", 64'(bus.dout_leaf_interface2bft), 64'(p));
    chk("t1_ack", 64'(bus.ack_interface2user), 64'h1);
    chk("t1_credit", 64'(dut.credit_q[0]), 64'd127);
    uvld = '0;
    step('0, 1'b0);
    chk("t1_ack_once", 64'(bus.ack_interface2user), 64'h0);

    // Round-robin rotation with all channels busy
    for (int c = 1; c < N; c++) step(mk_ctrl(2'b00, c, c + 4, c + 8), 1'b0);
    uvld = 4'hF;
    expch = 1;
    cnt = '{1, 0, 0, 0};
    for (int k = 0; k < 12; k++) begin
      step('0, 1'b0);
      chk("rr_order", 64'(bus.ack_interface2user), 64'(1 << expch));
      chk("rr_seq", 64'(bus.dout_leaf_interface2bft[PL +: AB]), 64'(cnt[expch]));
      cnt[expch]++;
      expch = (expch + 1) % N;
    end
    uvld = '0;
    step('0, 1'b0);

    // Credit exhaustion on ch1 and recovery via credit return
    do_reset();
    step(mk_ctrl(2'b00, 1, 5, 6), 1'b0);
    uvld = 4'b0010;
    n = 0;
    for (int c = 0; c < 400 && n < 128; c++) begin
      step('0, 1'b0);
      if (bus.ack_interface2user[1]) n++;
    end
    chk("t3_grants", 64'(n), 64'd128);
    for (int k = 0; k < 4; k++) begin
      step('0, 1'b0);
      chk("t3_stall_ack", 64'(bus.ack_interface2user), 64'h0);
      chk("t3_stall_vld", 64'(bus.dout_leaf_interface2bft[PB-1]), 64'h0);
    end
    chk("t3_credit0", 64'(dut.credit_q[1]), 64'd0);
    step(mk_ctrl(2'b01, 1, 0, 0), 1'b0);
    chk("t3_ret_noack", 64'(bus.ack_interface2user), 64'h0);
    step('0, 1'b0);
    chk("t3_resume_ack", 64'(bus.ack_interface2user), 64'h2);
    chk("t3_credit63", 64'(dut.credit_q[1]), 64'd63);
    uvld = '0;
    step('0, 1'b0);

    // Same-cycle grant and credit return on ch2 at credit 10
    step(mk_ctrl(2'b00, 2, 7, 1), 1'b0);
    uvld = 4'b0100;
    for (int c = 0; c < 400 && m_credit[2] > 10; c++) step('0, 1'b0);
    if (m_ack[2]) step('0, 1'b0);
    chk("t4_credit10", 64'(dut.credit_q[2]), 64'd10);
    step(mk_ctrl(2'b01, 2, 0, 0), 1'b0);
    chk("t4_ack", 64'(bus.ack_interface2user), 64'h4);
    chk("t4_credit73", 64'(dut.credit_q[2]), 64'd73);
    uvld = '0;
    step('0, 1'b0);

    // Saturation: return at credit 120 on ch3
    step(mk_ctrl(2'b00, 3, 9, 3), 1'b0);
    uvld = 4'b1000;
    for (int c = 0; c < 100 && m_credit[3] > 120; c++) step('0, 1'b0);
    uvld = '0;
    step('0, 1'b0);
    chk("t4_credit120", 64'(dut.credit_q[3]), 64'd120);
    step(mk_ctrl(2'b01, 3, 0, 0), 1'b0);
    step('0, 1'b0);
    chk("t4_sat128", 64'(dut.credit_q[3]), 64'd128);

    // Resend pulse, then held resend
    step(mk_ctrl(2'b00, 0, 12, 13), 1'b0);
    uvld = 4'b0001;
    step('0, 1'b0);
    p = m_last;
    chk("t5_first_ack", 64'(bus.ack_interface2user), 64'h1);
    step('0, 1'b1);
    chk("t5_resend_pkt", 64'(bus.dout_leaf_interface2bft), 64'(p));
    chk("t5_resend_noack", 64'(bus.ack_interface2user), 64'h0);
    step('0, 1'b0);
    chk("t5_resume_ack", 64'(bus.ack_interface2user), 64'h1);
    chk("t5_resume_seq", 64'(bus.dout_leaf_interface2bft[PL +: AB]), 64'(7'(p[PL +: AB] + 7'd1)));
    p = m_last;
    for (int k = 0; k < 3; k++) begin
      step('0, 1'b1);
      chk("t5_hold_pkt", 64'(bus.dout_leaf_interface2bft), 64'(p));
    end

    // Sequence wrap 127 -> 0 on ch0, topping up credit as needed
    wrapped = 0;
    last_seq = -1;
    for (int c = 0; c < 1000 && !wrapped; c++) begin
      step((m_credit[0] < 32) ? mk_ctrl(2'b01, 0, 0, 0) : '0, 1'b0);
      if (bus.ack_interface2user[0]) begin
        if (last_seq == 127) begin
          chk("seq_wrap", 64'(bus.dout_leaf_interface2bft[PL +: AB]), 64'd0);
          wrapped = 1;
        end
        last_seq = int'(bus.dout_leaf_interface2bft[PL +: AB]);
      end
    end
    chk("seq_wrap_reached", 64'(wrapped), 64'd1);
    uvld = '0;
    step('0, 1'b0);

    // Random traffic, control and resend
    for (int c = 0; c < 400; c++) begin
      logic [PB-1:0] ctl;
      int r;
      uvld = 4'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        0, 1: ctl = mk_ctrl(2'b00, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        2, 3: ctl = mk_ctrl(2'b01, $urandom_range(0, 7), 0, 0);
        4:    ctl = mk_ctrl(2'($urandom_range(2, 3)), $urandom_range(0, 3), 1, 1);
        5:    begin ctl = {$urandom, $urandom}; ctl[PB-2] = 1'b0; end
        default: ctl = '0;
      endcase
      step(ctl, ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset mid-stream
    uvld = 4'hF;
    step('0, 1'b0);
    step('0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("midreset_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
    chk("midreset_ack", 64'(bus.ack_interface2user), 64'd0);
    for (int i = 0; i < N; i++) chk("midreset_credit", 64'(dut.credit_q[i]), 64'(CMAX));
    model_reset();
    uvld = '0;
    #2 reset = 1'b1;
    step(mk_ctrl(2'b00, 2, 1, 1), 1'b0);
    uvld = 4'b0100;
    step('0, 1'b0);
    chk("postreset_seq0", 64'(bus.dout_leaf_interface2bft[PL +: AB]), 64'd0);
    chk("postreset_ack", 64'(bus.ack_interface2user), 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/leaf_credit_tx.md
Name: leaf_credit_tx

Overview:
- Parametrised user-to-BFT transmit side of a leaf interface.
- Serves NUM_IN_PORTS ap_vld/ap_ack user streams, using round-robin arbitration and per-channel credit flow control.
- Destinations are programmed at runtime; supports single-packet resend.
- Sits between user stream ports and the leaf's BFT port; a sink-side block handles returned data.

Parameters:
- PACKET_BITS, 49, packet width; must equal 1+1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS.
- PAYLOAD_BITS, 32, user data width.
- NUM_LEAF_BITS, 4, destination leaf field width.
- NUM_PORT_BITS, 4, destination port / channel index width.
- NUM_ADDR_BITS, 7, sequence field width.
- NUM_IN_PORTS, 4, user input channels (1..2^NUM_PORT_BITS).
- NUM_BRAM_ADDR_BITS, 7, log2 of remote buffer depth; initial credit = 2^NUM_BRAM_ADDR_BITS.
- FREESPACE_UPDATE_SIZE, 64, credits added per credit-return packet.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- din_leaf_bft2interface  in  PACKET_BITS  control packets from BFT
- dout_leaf_interface2bft  out  PACKET_BITS  data packets to BFT, registered
- resend  in  1  retransmit the last packet
- din_leaf_user2interface  in  NUM_IN_PORTS*PAYLOAD_BITS  channel i data at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_user2interface  in  NUM_IN_PORTS  per-channel valid
- ack_interface2user  out  NUM_IN_PORTS  per-channel ack, one-cycle pulse, registered

Behaviour:
- Packet layout, MSB down: valid, type (0 data / 1 control), leaf, port, addr, payload.
- Reset: dout = 0, ack = 0, credits = 2^NUM_BRAM_ADDR_BITS, sequence counters = 0, dest_valid = 0, RR pointer = 0. Reset applies asynchronously at any time; an in-flight packet or ack is dropped.
- Control input, when valid=1 and type=1, with opcode = payload[PAYLOAD_BITS-1:PAYLOAD_BITS-2] and channel ch = payload[NUM_PORT_BITS-1:0]:
  - opcode 00, config: dest_leaf[ch] = payload[8 +: NUM_LEAF_BITS], dest_port[ch] = payload[16 +: NUM_PORT_BITS], dest_valid[ch] = 1.
  - opcode 01, credit return: credit[ch] += FREESPACE_UPDATE_SIZE, saturating at 2^NUM_BRAM_ADDR_BITS.
  - Other opcodes, ch >= NUM_IN_PORTS, and type=0 input packets are ignored.
  - Control packets take effect for arbitration in the next cycle.
- Eligibility of channel i: vld[i] & dest_valid[i] & credit[i] != 0 & ~ack_interface2user[i]. The last term blocks re-capture of data the user is still holding during its ack cycle.
- Arbitration: round-robin starting at the RR pointer. After a grant to i, the pointer moves to i+1 mod NUM_IN_PORTS. At most one grant per cycle.
- Grant at cycle t, visible at t+1:
  - dout = {1, 0, dest_leaf[i], dest_port[i], seq[i], data_i}.
  - ack[i] = 1 for exactly one cycle.
  - seq[i] increments, wrapping at 2^NUM_ADDR_BITS.
  - credit[i] decrements.
- No grant: dout valid bit = 0; other fields don't-care (hold last).
- Credit width is NUM_BRAM_ADDR_BITS+1. A same-cycle grant and credit return on one channel nets +FREESPACE_UPDATE_SIZE-1, still saturating. Credit 0 stalls the channel; vld stays pending with no ack.
- resend=1 at cycle t:
  - dout at t+1 repeats the last packet that had valid=1, unchanged, including seq.
  - No grant, no ack, no credit or seq change in that cycle.
  - Resend held high repeats the packet every cycle.
  - Resend before any packet since reset outputs valid=0.
- Throughput: 1 packet/cycle aggregate. A single channel sustains at most 1 packet per 2 cycles because of the ack-exclusion rule.

Test Plan:
- Reset then config ch0 → leaf 3, port 2; hold vld[0] with data 0xDEADBEEF for 1 cycle → next cycle dout = {1,0,4'h3,4'h2,7'd0,32'hDEADBEEF}, ack[0] pulses once, credit[0] = 127.
- Config all 4 channels, hold all vld high with fresh data after each ack → grants rotate 0,1,2,3,0… with no channel served twice before the others; seq of each channel increments by 1 per grant.
- Send 128 packets on ch1 with no credit return → 129th stalls (no ack, dout valid=0). Inject credit-return for ch1 → grant resumes next cycle; credit after the grant = 63.
- Credit return arriving in the same cycle as a ch2 grant with credit=10 → credit = 73. A return at credit=120 saturates to 128.
- Packet out at t, resend pulse at t+1 → dout at t+2 is bit-identical to the packet at t+1, no ack; the next grant resumes at t+3 with seq continuing. Also cover seq wrap 127→0 and reset asserted mid-stream → all outputs 0 immediately.
